// File: rtl/gate_control_scheduler.sv
// gate_control_scheduler
// Runs a cyclic TSN gate control list against a free-running picosecond
// reference timer and drives one transmit gate bit per egress queue.
// Optional feature macro: GATE_SCHED_CYCLE_COUNT_EN adds the cycle_count
// output, which counts schedule wraps since the last accepted start.
module gate_control_scheduler #(
  parameter int TIMESTAMP_WIDTH = 72,
  parameter int NUM_QUEUES      = 8,
  parameter int GCL_DEPTH       = 16,
  parameter int INTERVAL_WIDTH  = 40,
  localparam int ADDR_W         = $clog2(GCL_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [TIMESTAMP_WIDTH-1:0] reference_timer,
  input  logic                       cfg_wr_en,
  input  logic [ADDR_W-1:0]          cfg_wr_addr,
  input  logic [NUM_QUEUES-1:0]      cfg_wr_gates,
  input  logic [INTERVAL_WIDTH-1:0]  cfg_wr_interval,
  input  logic [TIMESTAMP_WIDTH-1:0] cfg_base_time,
  input  logic [TIMESTAMP_WIDTH-1:0] cfg_cycle_time,
  input  logic [ADDR_W:0]            cfg_list_len,
  input  logic                       cfg_start,
  input  logic                       cfg_stop,
  output logic [NUM_QUEUES-1:0]      gate_states,
  output logic                       cycle_start,
  output logic [ADDR_W-1:0]          entry_index,
  output logic                       running,
  output logic                       config_error
`ifdef GATE_SCHED_CYCLE_COUNT_EN
  ,
  output logic [31:0]                cycle_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BASE,
    RUN
  } state_t;

  localparam logic [ADDR_W-1:0] FIRST_ENTRY = '0;

  // GCL storage; never cleared so a schedule survives reset
  logic [NUM_QUEUES-1:0]     gcl_gates    [GCL_DEPTH];
  logic [INTERVAL_WIDTH-1:0] gcl_interval [GCL_DEPTH];

  state_t                     state;
  logic [TIMESTAMP_WIDTH-1:0] base_r;
  logic [TIMESTAMP_WIDTH-1:0] cycle_r;
  logic [ADDR_W:0]            len_r;
  logic [TIMESTAMP_WIDTH-1:0] cyc_start;
  logic [TIMESTAMP_WIDTH-1:0] ent_end;

  logic [TIMESTAMP_WIDTH-1:0] cyc_end;
  logic [ADDR_W-1:0]          idx_next;
  logic                       not_last;
  logic                       cfg_valid;
  logic                       wrap_now;
  logic                       advance_now;

  // Entry writes from the management block, dropped while reset is held
  always_ff @(posedge clk) begin
    if (rstn && cfg_wr_en) begin
      gcl_gates[cfg_wr_addr]    <= cfg_wr_gates;
      gcl_interval[cfg_wr_addr] <= cfg_wr_interval;
    end
  end

  assign cyc_end   = cyc_start + cycle_r;
  assign idx_next  = entry_index + ADDR_W'(1);
  assign not_last  = ({1'b0, entry_index} < (len_r - (ADDR_W + 1)'(1)));
  assign cfg_valid = (cfg_list_len != '0) &&
                     (cfg_list_len <= (ADDR_W + 1)'(GCL_DEPTH)) &&
                     (cfg_cycle_time != '0);

  // A cycle wrap takes priority over an entry advance; start/stop pulses
  // override both so the schedule never steps in the same clock as a reconfig.
  assign wrap_now    = (state == RUN) && !cfg_stop && !cfg_start &&
                       (reference_timer >= cyc_end);
  assign advance_now = (state == RUN) && !cfg_stop && !cfg_start && !wrap_now &&
                       (reference_timer >= ent_end) && not_last;

  // Schedule sequencer: configuration latching, base wait, entry stepping
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= IDLE;
      base_r       <= '0;
      cycle_r      <= '0;
      len_r        <= '0;
      cyc_start    <= '0;
      ent_end      <= '0;
      gate_states  <= '1;
      cycle_start  <= 1'b0;
      entry_index  <= '0;
      running      <= 1'b0;
      config_error <= 1'b0;
    end else begin
      cycle_start <= 1'b0;
      if (cfg_stop) begin
        state       <= IDLE;
        gate_states <= '1;
        entry_index <= '0;
        running     <= 1'b0;
      end else if (cfg_start) begin
        gate_states <= '1;
        entry_index <= '0;
        running     <= 1'b0;
        if (cfg_valid) begin
          state        <= WAIT_BASE;
          config_error <= 1'b0;
          cycle_r      <= cfg_cycle_time;
          len_r        <= cfg_list_len;
          base_r       <= (reference_timer >= cfg_base_time) ? reference_timer
                                                             : cfg_base_time;
        end else begin
          state        <= IDLE;
          config_error <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
          end
          WAIT_BASE: begin
            if (reference_timer >= base_r) begin
              state       <= RUN;
              running     <= 1'b1;
              cyc_start   <= base_r;
              ent_end     <= base_r + TIMESTAMP_WIDTH'(gcl_interval[FIRST_ENTRY]);
              entry_index <= FIRST_ENTRY;
              gate_states <= gcl_gates[FIRST_ENTRY];
              cycle_start <= 1'b1;
            end
          end
          RUN: begin
            if (wrap_now) begin
              cyc_start   <= cyc_end;
              ent_end     <= cyc_end + TIMESTAMP_WIDTH'(gcl_interval[FIRST_ENTRY]);
              entry_index <= FIRST_ENTRY;
              gate_states <= gcl_gates[FIRST_ENTRY];
              cycle_start <= 1'b1;
            end else if (advance_now) begin
              entry_index <= idx_next;
              ent_end     <= ent_end + TIMESTAMP_WIDTH'(gcl_interval[idx_next]);
              gate_states <= gcl_gates[idx_next];
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef GATE_SCHED_CYCLE_COUNT_EN
  // Wrap counter, restarted by every accepted configuration
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cycle_count <= '0;
    end else if (!cfg_stop && cfg_start && cfg_valid) begin
      cycle_count <= '0;
    end else if (wrap_now) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_control_scheduler.sv
// tb_gate_control_scheduler
// Directed vectors for gate_control_scheduler with the reference timer
// advancing 8000 ps per clock. Schedule checkpoints live in a table keyed by
// timer value relative to the schedule base; corner cases are hand sequenced.
module tb_gate_control_scheduler;

  logic        clk;
  logic        rstn;
  longint      timer;
  logic        cfg_wr_en;
  logic [3:0]  cfg_wr_addr;
  logic [7:0]  cfg_wr_gates;
  logic [39:0] cfg_wr_interval;
  logic [71:0] cfg_base_time;
  logic [71:0] cfg_cycle_time;
  logic [4:0]  cfg_list_len;
  logic        cfg_start;
  logic        cfg_stop;
  logic [7:0]  gate_states;
  logic        cycle_start;
  logic [3:0]  entry_index;
  logic        running;
  logic        config_error;
`ifdef GATE_SCHED_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  int     checks;
  int     errors;
  longint last_sampled;
  longint base;

  typedef struct {
    int         section;
    longint     offset;
    logic [7:0] gates;
    logic       cs;
    logic [3:0] idx;
    logic       run;
  } vec_t;

  vec_t vecs[$];

  gate_control_scheduler dut (
    .clk             (clk),
    .rstn            (rstn),
    .reference_timer ({8'b0, timer}),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_addr     (cfg_wr_addr),
    .cfg_wr_gates    (cfg_wr_gates),
    .cfg_wr_interval (cfg_wr_interval),
    .cfg_base_time   (cfg_base_time),
    .cfg_cycle_time  (cfg_cycle_time),
    .cfg_list_len    (cfg_list_len),
    .cfg_start       (cfg_start),
    .cfg_stop        (cfg_stop),
    .gate_states     (gate_states),
    .cycle_start     (cycle_start),
    .entry_index     (entry_index),
    .running         (running),
    .config_error    (config_error)
`ifdef GATE_SCHED_CYCLE_COUNT_EN
    ,
    .cycle_count     (cycle_count)
`endif
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input int s, input longint o, input logic [7:0] g,
                              input logic c, input logic [3:0] i, input logic r);
    vec_t v;
    v.section = s;
    v.offset  = o;
    v.gates   = g;
    v.cs      = c;
    v.idx     = i;
    v.run     = r;
    return v;
  endfunction

  task automatic checkValue(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] g, input logic c,
                             input logic [3:0] i, input logic r);
    checkValue({name, ".gates"}, longint'(gate_states), longint'(g));
    checkValue({name, ".cycle_start"}, longint'(cycle_start), longint'(c));
    checkValue({name, ".entry_index"}, longint'(entry_index), longint'(i));
    checkValue({name, ".running"}, longint'(running), longint'(r));
  endtask

  // One clock: DUT samples the current timer, outputs are read #1 later
  task automatic stepClock();
    @(posedge clk);
    last_sampled = timer;
    #1;
    timer = timer + 8000;
  endtask

  task automatic applyStimulus(input logic start, input logic stop, input longint b,
                               input longint cyc, input int len);
    cfg_start      = start;
    cfg_stop       = stop;
    cfg_base_time  = 72'(b);
    cfg_cycle_time = 72'(cyc);
    cfg_list_len   = 5'(len);
    stepClock();
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
  endtask

  task automatic writeEntry(input int addr, input logic [7:0] g, input longint iv);
    cfg_wr_en       = 1'b1;
    cfg_wr_addr     = 4'(addr);
    cfg_wr_gates    = g;
    cfg_wr_interval = 40'(iv);
    stepClock();
    cfg_wr_en = 1'b0;
  endtask

  task automatic runTo(input longint t);
    int n;
    n = 0;
    while (last_sampled < t && n < 5000) begin
      stepClock();
      n++;
    end
    if (last_sampled != t) begin
      checks++;
      errors++;
      $display("[TB] FAIL runTo actual=%0d expected=%0d", last_sampled, t);
    end
  endtask

  task automatic runTable(input int section, input longint b);
    foreach (vecs[k]) begin
      if (vecs[k].section == section) begin
        runTo(b + vecs[k].offset);
        checkOutput($sformatf("sec%0d@+%0d", section, vecs[k].offset),
                    vecs[k].gates, vecs[k].cs, vecs[k].idx, vecs[k].run);
      end
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    timer           = 0;
    last_sampled    = -1;
    rstn            = 1'b0;
    cfg_wr_en       = 1'b0;
    cfg_wr_addr     = '0;
    cfg_wr_gates    = '0;
    cfg_wr_interval = '0;
    cfg_base_time   = '0;
    cfg_cycle_time  = '0;
    cfg_list_len    = '0;
    cfg_start       = 1'b0;
    cfg_stop        = 1'b0;

    // Section 0: two-entry basic schedule, absolute base 800000
    vecs.push_back(mk(0, -8000,  8'hFF, 1'b0, 4'd0, 1'b0));
    vecs.push_back(mk(0, 0,      8'h01, 1'b1, 4'd0, 1'b1));
    vecs.push_back(mk(0, 8000,   8'h01, 1'b0, 4'd0, 1'b1));
    vecs.push_back(mk(0, 72000,  8'h01, 1'b0, 4'd0, 1'b1));
    vecs.push_back(mk(0, 80000,  8'h02, 1'b0, 4'd1, 1'b1));
    vecs.push_back(mk(0, 232000, 8'h02, 1'b0, 4'd1, 1'b1));
    vecs.push_back(mk(0, 240000, 8'h01, 1'b1, 4'd0, 1'b1));
    vecs.push_back(mk(0, 248000, 8'h01, 1'b0, 4'd0, 1'b1));
    vecs.push_back(mk(0, 320000, 8'h02, 1'b0, 4'd1, 1'b1));
    vecs.push_back(mk(0, 480000, 8'h01, 1'b1, 4'd0, 1'b1));
    // Section 1: second entry truncated by the wrap
    vecs.push_back(mk(1, 0,      8'h01, 1'b1, 4'd0, 1'b1));
    vecs.push_back(mk(1, 152000, 8'h01, 1'b0, 4'd0, 1'b1));
    vecs.push_back(mk(1, 160000, 8'h02, 1'b0, 4'd1, 1'b1));
    vecs.push_back(mk(1, 232000, 8'h02, 1'b0, 4'd1, 1'b1));
    vecs.push_back(mk(1, 240000, 8'h01, 1'b1, 4'd0, 1'b1));
    vecs.push_back(mk(1, 400000, 8'h02, 1'b0, 4'd1, 1'b1));
    vecs.push_back(mk(1, 480000, 8'h01, 1'b1, 4'd0, 1'b1));
    // Section 2: single entry held for the whole cycle
    vecs.push_back(mk(2, 0,      8'h04, 1'b1, 4'd0, 1'b1));
    vecs.push_back(mk(2, 80000,  8'h04, 1'b0, 4'd0, 1'b1));
    vecs.push_back(mk(2, 232000, 8'h04, 1'b0, 4'd0, 1'b1));
    vecs.push_back(mk(2, 240000, 8'h04, 1'b1, 4'd0, 1'b1));
    vecs.push_back(mk(2, 248000, 8'h04, 1'b0, 4'd0, 1'b1));
    vecs.push_back(mk(2, 480000, 8'h04, 1'b1, 4'd0, 1'b1));
    // Section 3: late base, relative to the timer sampled with cfg_start
    vecs.push_back(mk(3, 8000,   8'h04, 1'b1, 4'd0, 1'b1));
    vecs.push_back(mk(3, 16000,  8'h04, 1'b0, 4'd0, 1'b1));
    vecs.push_back(mk(3, 232000, 8'h04, 1'b0, 4'd0, 1'b1));
    vecs.push_back(mk(3, 240000, 8'h04, 1'b1, 4'd0, 1'b1));

    // Reset state
    repeat (3) stepClock();
    checkOutput("reset", 8'hFF, 1'b0, 4'd0, 1'b0);
    checkValue("reset.config_error", longint'(config_error), 0);
    rstn = 1'b1;

    // Basic schedule
    writeEntry(0, 8'h01, 80000);
    writeEntry(1, 8'h02, 160000);
    applyStimulus(1'b1, 1'b0, 800000, 240000, 2);
    checkOutput("basic.wait", 8'hFF, 1'b0, 4'd0, 1'b0);
    runTable(0, 800000);
`ifdef GATE_SCHED_CYCLE_COUNT_EN
    checkValue("basic.cycle_count", longint'(cycle_count), 2);
`endif

    // Stop, then truncation schedule with a new base
    applyStimulus(1'b0, 1'b1, 0, 0, 0);
    checkOutput("stop1", 8'hFF, 1'b0, 4'd0, 1'b0);
    writeEntry(0, 8'h01, 160000);
    writeEntry(1, 8'h02, 160000);
    base = timer + 80000;
    applyStimulus(1'b1, 1'b0, base, 240000, 2);
    runTable(1, base);

    // Short list
    applyStimulus(1'b0, 1'b1, 0, 0, 0);
    writeEntry(0, 8'h04, 80000);
    base = timer + 80000;
    applyStimulus(1'b1, 1'b0, base, 240000, 1);
    runTable(2, base);

    // Invalid configurations issued while running
    applyStimulus(1'b1, 1'b0, 0, 240000, 0);
    checkOutput("bad.len0", 8'hFF, 1'b0, 4'd0, 1'b0);
    checkValue("bad.len0.config_error", longint'(config_error), 1);
    applyStimulus(1'b1, 1'b0, 0, 0, 1);
    checkValue("bad.cycle0.config_error", longint'(config_error), 1);
    applyStimulus(1'b1, 1'b0, 0, 240000, 17);
    checkValue("bad.len17.config_error", longint'(config_error), 1);
    checkValue("bad.len17.running", longint'(running), 0);
    stepClock();
    checkValue("bad.sticky", longint'(config_error), 1);

    // Valid start clears the error; stop mid-RUN
    base = timer + 16000;
    applyStimulus(1'b1, 1'b0, base, 240000, 1);
    checkValue("good.config_error", longint'(config_error), 0);
    checkValue("good.wait_running", longint'(running), 0);
    runTo(base);
    checkOutput("good.run", 8'h04, 1'b1, 4'd0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b1, 0, 0, 0);
    checkOutput("stop.mid", 8'hFF, 1'b0, 4'd0, 1'b0);

    // Reset mid-RUN
    base = timer + 16000;
    applyStimulus(1'b1, 1'b0, base, 240000, 1);
    runTo(base + 8000);
    checkValue("prereset.running", longint'(running), 1);
    rstn = 1'b0;
    stepClock();
    checkOutput("reset.mid", 8'hFF, 1'b0, 4'd0, 1'b0);
    rstn = 1'b1;

    // Late base: schedule anchors on the timer sampled with cfg_start
    applyStimulus(1'b1, 1'b0, 0, 240000, 1);
    base = last_sampled;
    checkValue("late.wait_running", longint'(running), 0);
    runTable(3, base);

    // Start and stop in the same clock: stop wins
    applyStimulus(1'b1, 1'b1, 0, 240000, 1);
    checkOutput("startstop", 8'hFF, 1'b0, 4'd0, 1'b0);
    repeat (3) stepClock();
    checkOutput("startstop.hold", 8'hFF, 1'b0, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
